framebuffer_reader: RTL

//  Bus-master DMA that reads a grayscale frame (4 pixels/word) from memory via burst reads.

---
 rtl/framebuffer_reader.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_reader.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// framebuffer_reader : burst-read DMA streaming a 4-pixel/word frame as pixels
// Rev 1.0
//==============================================================================
module framebuffer_reader #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         fifoDepthLog2       = 5,
  parameter int         maxBurst            = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        endTransactionOut,
  output logic [3:0]  byteEnablesOut,
  output logic        readNotWriteOut,
  output logic [7:0]  burstSizeOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  input  logic        busErrorIn,
  output logic [7:0]  pixelData,
  output logic        pixelValid,
  input  logic        pixelReady,
  output logic        frameStart
);

  localparam logic [fifoDepthLog2:0] c_depth       = (fifoDepthLog2+1)'(1 << fifoDepthLog2);
  localparam logic [fifoDepthLog2:0] c_burst_slots = (fifoDepthLog2+1)'(maxBurst);
  localparam logic [19:0]            c_max_burst   = 20'(maxBurst);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_INIT    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q, bus_addr_q;
  logic [19:0] remaining_q;
  logic [7:0]  burst_q;
  logic        request_q, begin_q, end_q;

  logic [31:0] base_q, base_d;
  logic [19:0] words_q, words_d, pop_left_q, pop_left_d;
  logic        running_q, running_d, continuous_q, continuous_d;
  logic        frame_done_q, frame_done_d, error_q, error_d;
  logic        in_frame_q, in_frame_d, start_pend_q, start_pend_d;

  logic [31:0]              mem_q [0:(1 << fifoDepthLog2)-1];
  logic [fifoDepthLog2:0]   count_q, count_d;
  logic [fifoDepthLog2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]               byte_sel_q, byte_sel_d;

  logic                   w_ci_active, w_frame_start, w_push, w_pop, w_fire, w_pix_valid;
  logic [fifoDepthLog2:0] w_free;
  logic [7:0]             w_burst_len, w_head_byte;
  logic [31:0]            w_head;
  logic                   w_unused;

  assign w_unused      = ^{ciValueA[31:3], busyIn};
  assign w_ci_active   = ciStart && ciCke && (ciN == customInstructionId);
  assign w_free        = c_depth - count_q;
  assign w_burst_len   = (remaining_q >= c_max_burst) ? 8'(maxBurst) : remaining_q[7:0];
  assign w_frame_start = running_q && (state_q == ST_IDLE) && (count_q == '0) &&
                         !in_frame_q && (words_q != 20'd0);
  // Words arriving alongside an error are dropped with the rest of the burst.
  assign w_push        = (state_q == ST_WAIT) && dataValidIn && !busErrorIn;
  assign w_pix_valid   = (count_q != '0);
  assign w_fire        = w_pix_valid && pixelReady;
  assign w_pop         = w_fire && (byte_sel_q == 2'd3);
  assign w_head        = mem_q[rd_ptr_q];

  always_comb begin
    case (byte_sel_q)
      2'd0:    w_head_byte = w_head[7:0];
      2'd1:    w_head_byte = w_head[15:8];
      2'd2:    w_head_byte = w_head[23:16];
      default: w_head_byte = w_head[31:24];
    endcase
  end

  assign ciDone              = w_ci_active;
  assign requestBus          = request_q;
  assign beginTransactionOut = begin_q;
  assign addressDataOut      = bus_addr_q;
  assign endTransactionOut   = end_q;
  assign byteEnablesOut      = begin_q ? 4'hF : 4'h0;
  assign readNotWriteOut     = begin_q;
  assign burstSizeOut        = burst_q;
  assign pixelValid          = w_pix_valid;
  assign pixelData           = w_pix_valid ? w_head_byte : 8'd0;
  assign frameStart          = start_pend_q && w_pix_valid;

  always_comb begin
    ciResult = 32'd0;
    if (w_ci_active) begin
      case (ciValueA[2:0])
        3'd0:    ciResult = base_q;
        3'd3:    ciResult = {12'd0, words_q};
        3'd5:    ciResult = {29'd0, error_q, frame_done_q, running_q};
        default: ciResult = 32'd0;
      endcase
    end
  end

  // Bus outputs are registered and follow the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 20'd0;
      request_q   <= 1'b0;
      begin_q     <= 1'b0;
      end_q       <= 1'b0;
      bus_addr_q  <= 32'd0;
      burst_q     <= 8'd0;
    end else begin
      request_q  <= 1'b0;
      begin_q    <= 1'b0;
      end_q      <= 1'b0;
      bus_addr_q <= 32'd0;
      burst_q    <= 8'd0;
      case (state_q)
        ST_IDLE: begin
          if (w_frame_start) begin
            addr_q      <= base_q;
            remaining_q <= words_q;
          end else if ((remaining_q != 20'd0) && (w_free >= c_burst_slots)) begin
            state_q   <= ST_REQUEST;
            request_q <= 1'b1;
          end
        end
        ST_REQUEST: begin
          if (busGrant) begin
            state_q    <= ST_INIT;
            begin_q    <= 1'b1;
            bus_addr_q <= addr_q;
            burst_q    <= w_burst_len - 8'd1;
          end else begin
            request_q <= 1'b1;
          end
        end
        ST_INIT: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (busErrorIn) begin
            state_q <= ST_ERROR;
            end_q   <= 1'b1;
          end else begin
            if (dataValidIn && (remaining_q != 20'd0)) begin
              addr_q      <= addr_q + 32'd4;
              remaining_q <= remaining_q - 20'd1;
            end
            if (endTransactionIn) state_q <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          state_q     <= ST_IDLE;
          remaining_q <= 20'd0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    base_d       = base_q;
    words_d      = words_q;
    running_d    = running_q;
    continuous_d = continuous_q;
    frame_done_d = frame_done_q;
    error_d      = error_q;
    in_frame_d   = in_frame_q;
    pop_left_d   = pop_left_q;
    start_pend_d = start_pend_q;
    if (w_ci_active) begin
      case (ciValueA[2:0])
        3'd1: base_d  = {ciValueB[31:2], 2'b00};
        3'd2: words_d = ciValueB[19:0];
        3'd4: begin
          case (ciValueB[1:0])
            2'b01: begin running_d = 1'b1; continuous_d = 1'b1; end
            2'b10: begin running_d = 1'b1; continuous_d = 1'b0; end
            2'b00: begin
              continuous_d = 1'b0;
              if (!in_frame_q) running_d = 1'b0;
            end
            default: ;
          endcase
        end
        3'd5: begin frame_done_d = 1'b0; error_d = 1'b0; end
        default: ;
      endcase
    end
    if (w_frame_start) begin
      in_frame_d   = 1'b1;
      pop_left_d   = words_q;
      start_pend_d = 1'b1;
    end
    if (w_fire) start_pend_d = 1'b0;
    // A flag set here overrides the clear from a same-cycle status read.
    if (w_pop && in_frame_q) begin
      pop_left_d = pop_left_q - 20'd1;
      if (pop_left_q == 20'd1) begin
        frame_done_d = 1'b1;
        in_frame_d   = 1'b0;
        if (!continuous_d) running_d = 1'b0;
      end
    end
    if (state_q == ST_ERROR) begin
      error_d    = 1'b1;
      running_d  = 1'b0;
      in_frame_d = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_sel_d = byte_sel_q;
    if (w_push) wr_ptr_d = wr_ptr_q + fifoDepthLog2'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + fifoDepthLog2'(1);
    if (w_fire) byte_sel_d = byte_sel_q + 2'd1;
    if (w_push && !w_pop)      count_d = count_q + (fifoDepthLog2+1)'(1);
    else if (!w_push && w_pop) count_d = count_q - (fifoDepthLog2+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      base_q       <= 32'd0;
      words_q      <= 20'd0;
      running_q    <= 1'b0;
      continuous_q <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      in_frame_q   <= 1'b0;
      pop_left_q   <= 20'd0;
      start_pend_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      byte_sel_q   <= 2'd0;
    end else begin
      base_q       <= base_d;
      words_q      <= words_d;
      running_q    <= running_d;
      continuous_q <= continuous_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      in_frame_q   <= in_frame_d;
      pop_left_q   <= pop_left_d;
      start_pend_q <= start_pend_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_sel_q   <= byte_sel_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_ptr_q] <= addressDataIn;
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
    !(w_push && !w_pop && (count_q == c_depth)));
`endif

endmodule
`default_nettype wire
